muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the execute stage, alongside the single-cycle ALU. It implements MULT, MULTU, DIV and DIVU over 32 compute cycles and holds the results in architectural HI/LO registers. While an operation is in flight it asserts `busy`, which the hazard unit uses to stall MFHI/MFLO and any new mul/div. It also services MTHI/MTLO writes.

## Interface
- `WIDTH`, default 32: operand width. The design is only verified at 32.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: launch an operation. Honoured only when `busy`=0.
- `mdControl` input 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `srcA` input 32: multiplicand or dividend. Sampled with `start`.
- `srcB` input 32: multiplier or divisor. Sampled with `start`.
- `hiWrite` input 1: MTHI strobe.
- `loWrite` input 1: MTLO strobe.
- `wrData` input 32: data for MTHI/MTLO.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse; HI/LO hold the new result.
- `divByZero` output 1: sticky flag for the last DIV/DIVU. Cleared by the next `start`.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States and transitions:
  - IDLE → CALC on `start`.
  - CALC → FIX after 32 iterations.
  - FIX → IDLE, asserting `done` on the FIX→IDLE edge.
  - IDLE on `start` with a divide by zero (`mdControl[1]`=1, `srcB`=0) → FIX directly.
- Load, on `start` in IDLE:
  - Signed ops (MULT, DIV) convert both operands to magnitude and record `negQ` = signA ^ signB and `negR` = signA.
  - Unsigned ops clear `negQ` and `negR`.
  - The iteration counter is set to 0.
- Multiply: unsigned shift-add on a 64-bit working register {acc, mplr}, with a 33-bit add so the carry is kept. Each CALC cycle: if mplr[0], acc += multiplicand; then the {carry, acc, mplr} value shifts right by 1.
- Divide: restoring division. The 33-bit remainder shifts left, bringing in the next dividend bit MSB-first, then the divisor is trial-subtracted. If the result is non-negative, the remainder updates and quotient bit = 1; otherwise quotient bit = 0.
- FIX:
  - Multiply: if `negQ`, the 64-bit product is two's-complement negated. `hi` gets product[63:32] and `lo` gets product[31:0].
  - Divide: `lo` = quotient, negated if `negQ`. `hi` = remainder, negated if `negR`.
  - Signed −2^31 / −1 yields `lo`=0x80000000 and `hi`=0 with no flag.
  - Divide by zero: `hi` = `srcA` as sampled, `lo` = 0xFFFFFFFF, `divByZero`=1.
- `hi` and `lo` never change during CALC. Working registers are separate.
- MTHI/MTLO:
  - Written at the clock edge when `busy`=0 and `start`=0.
  - Dropped when `busy`=1 or `start`=1.
  - `hiWrite` and `loWrite` together write both registers.
- `start` while `busy`=1 is ignored. The hazard unit guarantees this never happens; the block must still tolerate it.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `divByZero`=0, `hi`=0, `lo`=0, and all working registers cleared.
- Reset asserted mid-operation aborts to IDLE immediately. No `done` pulse follows, and `hi`/`lo` read 0.
- Normal operation, with `start` sampled at the end of cycle 0:
  - cycles 1–32: CALC, `busy`=1.
  - cycle 33: FIX, `busy`=1.
  - cycle 34: `busy`=0, `done`=1, and the new `hi`/`lo` are visible.
  - Total latency: 34 cycles from `start` to `done`.
- Divide by zero: FIX in cycle 1, `done`=1 in cycle 2.
- `busy` is combinational from the state: state ≠ IDLE.
- `done` is registered and lasts exactly one cycle.
- A new `start` in the `done` cycle is accepted. Back-to-back operations therefore have a 34-cycle issue interval.
- MTHI/MTLO take effect on the next cycle. They have no handshake and do not affect `busy` or `done`.

## Test plan
- **MULTU** 0xFFFFFFFF × 0xFFFFFFFF → `done` in cycle 34; `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **MULT** −7 × 6 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFD6. **MULT** 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- **DIV** −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. **DIVU** 100 / 7 → `lo`=14, `hi`=2. **DIV** 0x80000000 / −1 → `lo`=0x80000000, `hi`=0.
- **DIVU** 5 / 0 → `done` in cycle 2; `hi`=5, `lo`=0xFFFFFFFF, `divByZero`=1. A following MULTU 3×3 clears the flag and gives `lo`=9.
- **Stray inputs during an operation:** `start` pulsed in cycles 5 and 20 is ignored. MTLO 0x1234 in cycle 10 is dropped and `hi`/`lo` keep their prior values until `done`. MTHI 0xABCD while idle → `hi`=0xABCD next cycle.
- **Reset mid-operation:** `reset` asserted in cycle 15 of a DIV → `busy`=0 and `hi`=`lo`=0 without waiting for a clock edge, and no `done` pulse follows. A new MULTU 2×3 after release → `lo`=6 in cycle 34.

Source files
------------

// File: rtl/muldiv_if.sv
// Handshake and result bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       mdControl;
   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] srcB;
   logic             hiWrite;
   logic             loWrite;
   logic [WIDTH-1:0] wrData;
   logic             busy;
   logic             done;
   logic             divByZero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, mdControl, srcA, srcB, hiWrite, loWrite, wrData,
      input  busy, done, divByZero, hi, lo
   );

   modport slave (
      input  start, mdControl, srcA, srcB, hiWrite, loWrite, wrData,
      output busy, done, divByZero, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide
// on magnitudes, sign fix-up in a final cycle, results held in HI/LO.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic     clk,
   input logic     reset,
   muldiv_if.slave md
);
   localparam int CW = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic             is_div, dz, negQ, negR;
   logic [WIDTH-1:0] acc, mplr, opb;
   logic [WIDTH-1:0] hi_r, lo_r;
   logic             done_r, dbz_r;

   logic signed [WIDTH-1:0] sa_s, sb_s;
   logic             sgn_op, start_dz;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [PW-1:0]    prod;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                            input logic en);
      return (en && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
   endfunction

   function automatic logic [WIDTH-1:0] negw(input logic en, input logic [WIDTH-1:0] v);
      return en ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [PW-1:0] neg2(input logic en, input logic [PW-1:0] v);
      return en ? (~v + PW'(1)) : v;
   endfunction

   assign sa_s     = md.srcA;
   assign sb_s     = md.srcB;
   assign sgn_op   = ~md.mdControl[0];
   assign start_dz = md.mdControl[1] && (md.srcB == '0);

   // One iteration of each algorithm; the 33-bit width keeps the add carry
   // and the sign of the trial subtraction.
   assign mul_sum   = {1'b0, acc} + (mplr[0] ? {1'b0, opb} : '0);
   assign div_shift = {acc, mplr[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb};
   assign prod      = neg2(negQ, {acc, mplr});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (md.start) state_nxt = start_dz ? FIX : CALC;
         CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         negQ   <= 1'b0;
         negR   <= 1'b0;
         acc    <= '0;
         mplr   <= '0;
         opb    <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
      end else begin
         done_r <= (state == FIX);
         case (state)
            IDLE: begin
               if (md.start) begin
                  is_div <= md.mdControl[1];
                  dz     <= start_dz;
                  dbz_r  <= 1'b0;
                  cnt    <= '0;
                  acc    <= '0;
                  negQ   <= sgn_op & (sa_s[WIDTH-1] ^ sb_s[WIDTH-1]);
                  negR   <= sgn_op & sa_s[WIDTH-1];
                  // A zero divisor skips the iterations; keep the raw dividend for HI.
                  mplr   <= start_dz ? md.srcA : mag(sa_s, sgn_op);
                  opb    <= mag(sb_s, sgn_op);
               end else begin
                  if (md.hiWrite) hi_r <= md.wrData;
                  if (md.loWrite) lo_r <= md.wrData;
               end
            end
            CALC: begin
               cnt <= cnt + CW'(1);
               if (is_div) begin
                  acc  <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                  mplr <= {mplr[WIDTH-2:0], ~div_diff[WIDTH]};
               end else begin
                  acc  <= mul_sum[WIDTH:1];
                  mplr <= {mul_sum[0], mplr[WIDTH-1:1]};
               end
            end
            FIX: begin
               dbz_r <= dz;
               if (dz) begin
                  hi_r <= mplr;
                  lo_r <= '1;
               end else if (is_div) begin
                  hi_r <= negw(negR, acc);
                  lo_r <= negw(negQ, mplr);
               end else begin
                  hi_r <= prod[PW-1:WIDTH];
                  lo_r <= prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign md.busy      = (state != IDLE);
   assign md.done      = done_r;
   assign md.divByZero = dbz_r;
   assign md.hi        = hi_r;
   assign md.lo        = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random operations against an
// arithmetic reference model.
module tb_muldiv_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(W)) mdi ();
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .md(mdi));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] h,
                                     output logic [31:0] l, output logic z);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      z  = 1'b0;
      h  = '0;
      l  = '0;
      case (op)
         2'd0: begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
         end
         2'd1: begin
            p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
         end
         default: begin
            if (b == 0) begin
               z = 1'b1;
               h = a;
               l = 32'hFFFF_FFFF;
            end else if (op == 2'd2) begin
               q = sa / sb;
               r = sa % sb;
               p = 64'(q);
               l = p[31:0];
               p = 64'(r);
               h = p[31:0];
            end else begin
               l = a / b;
               h = a % b;
            end
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // Issue one operation in the current cycle and follow it to its done pulse.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el, ph, pl;
      logic        ez;
      int          cyc, exp_lat;
      string       id;
      ref_model(op, a, b, eh, el, ez);
      exp_lat = (op[1] && b == 0) ? 2 : 34;
      id = $sformatf("op%0d %h,%h", op, a, b);
      ph = mdi.hi;
      pl = mdi.lo;
      mdi.start     = 1'b1;
      mdi.mdControl = op;
      mdi.srcA      = a;
      mdi.srcB      = b;
      tick();
      mdi.start = 1'b0;
      cyc = 1;
      chk({"busy_c1 ", id}, 64'(mdi.busy), 64'd1);
      chk({"done_c1 ", id}, 64'(mdi.done), 64'd0);
      chk({"dbz_clr ", id}, 64'(mdi.divByZero), 64'd0);
      chk({"hold_c1 ", id}, {mdi.hi, mdi.lo}, {ph, pl});
      while (!mdi.done && cyc < 100) begin
         tick();
         cyc++;
      end
      chk({"latency ", id}, 64'(cyc), 64'(exp_lat));
      chk({"busy_end ", id}, 64'(mdi.busy), 64'd0);
      chk({"hi ", id}, 64'(mdi.hi), 64'(eh));
      chk({"lo ", id}, 64'(mdi.lo), 64'(el));
      chk({"dbz ", id}, 64'(mdi.divByZero), 64'(ez));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ph, pl, eh, el;
      logic        ez;
      int          cyc, bad, seen;

      reset         = 1'b1;
      mdi.start     = 1'b0;
      mdi.mdControl = 2'b00;
      mdi.srcA      = '0;
      mdi.srcB      = '0;
      mdi.hiWrite   = 1'b0;
      mdi.loWrite   = 1'b0;
      mdi.wrData    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(mdi.busy), 64'd0);
      chk("rst_done", 64'(mdi.done), 64'd0);
      chk("rst_dbz", 64'(mdi.divByZero), 64'd0);
      chk("rst_hilo", {mdi.hi, mdi.lo}, 64'd0);
      reset = 1'b0;
      tick();

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_max_const", {mdi.hi, mdi.lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(2'd0, 32'hFFFF_FFF9, 32'd6);
      chk("mult_neg_const", {mdi.hi, mdi.lo}, 64'hFFFF_FFFF_FFFF_FFD6);
      run_op(2'd0, 32'h8000_0000, 32'h8000_0000);
      chk("mult_min_const", {mdi.hi, mdi.lo}, 64'h4000_0000_0000_0000);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg_const", {mdi.hi, mdi.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'd3, 32'd100, 32'd7);
      chk("divu_const", {mdi.hi, mdi.lo}, {32'd2, 32'd14});
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_const", {mdi.hi, mdi.lo, 32'(mdi.divByZero)}, {32'd0, 32'h8000_0000, 32'd0});
      run_op(2'd3, 32'd5, 32'd0);
      chk("divz_const", {mdi.hi, mdi.lo}, {32'd5, 32'hFFFF_FFFF});
      run_op(2'd1, 32'd3, 32'd3);
      chk("after_dz_const", 64'(mdi.lo), 64'd9);

      // MTHI while idle
      pl = mdi.lo;
      mdi.hiWrite = 1'b1;
      mdi.wrData  = 32'hABCD;
      tick();
      mdi.hiWrite = 1'b0;
      chk("mthi_hi", 64'(mdi.hi), 64'hABCD);
      chk("mthi_lo", 64'(mdi.lo), 64'(pl));

      // Stray start/MTLO during an operation, and MTLO coinciding with start
      ph = mdi.hi;
      pl = mdi.lo;
      ref_model(2'd1, 32'h1234_5678, 32'h9, eh, el, ez);
      mdi.start     = 1'b1;
      mdi.mdControl = 2'd1;
      mdi.srcA      = 32'h1234_5678;
      mdi.srcB      = 32'h9;
      mdi.loWrite   = 1'b1;
      mdi.wrData    = 32'h5555;
      tick();
      mdi.start   = 1'b0;
      mdi.loWrite = 1'b0;
      cyc = 1;
      bad = 0;
      while (!mdi.done && cyc < 100) begin
         if ({mdi.hi, mdi.lo} !== {ph, pl}) bad++;
         mdi.start     = (cyc == 5 || cyc == 20);
         mdi.mdControl = 2'd2;
         mdi.srcA      = $urandom();
         mdi.srcB      = 32'd0;
         mdi.loWrite   = (cyc == 10);
         mdi.wrData    = 32'h1234;
         tick();
         cyc++;
      end
      mdi.start   = 1'b0;
      mdi.loWrite = 1'b0;
      chk("stray_hold", 64'(bad), 64'd0);
      chk("stray_latency", 64'(cyc), 64'd34);
      chk("stray_result", {mdi.hi, mdi.lo}, {eh, el});
      chk("stray_dbz", 64'(mdi.divByZero), 64'd0);
      tick();
      chk("stray_no_restart", 64'(mdi.busy), 64'd0);
      chk("done_one_cycle", 64'(mdi.done), 64'd0);

      // Reset in cycle 15 of a divide
      mdi.start     = 1'b1;
      mdi.mdControl = 2'd2;
      mdi.srcA      = 32'd1000;
      mdi.srcB      = 32'd3;
      tick();
      mdi.start = 1'b0;
      cyc = 1;
      while (cyc < 15) begin
         tick();
         cyc++;
      end
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", 64'(mdi.busy), 64'd0);
      chk("rst_mid_hilo", {mdi.hi, mdi.lo}, 64'd0);
      tick();
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         tick();
         if (mdi.done) seen++;
      end
      chk("rst_mid_no_done", 64'(seen), 64'd0);
      run_op(2'd1, 32'd2, 32'd3);
      chk("after_rst_const", 64'(mdi.lo), 64'd6);

      // Random operations, some back-to-back, some with idle gaps
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         run_op(op, a, b);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
